// File: rtl/dmem_pkg.sv
// Shared constants for the data-side responder: MMIO decode and UART state encoding.
package dmem_pkg;

  localparam int MMIO_BASE_BIT = 31;

  // Word offsets within the MMIO window, decoded on data_addr[3:2]
  localparam logic [1:0] MMIO_LED       = 2'd0;
  localparam logic [1:0] MMIO_CYCLE     = 2'd1;
  localparam logic [1:0] MMIO_UART_DATA = 2'd2;
  localparam logic [1:0] MMIO_UART_STAT = 2'd3;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter: down-counting baud timer, 3-bit bit index, right-shift data register.
//
// state      | meaning
// UART_IDLE  | line high, ready for a new byte
// UART_START | start bit, line low
// UART_DATA  | 8 data bits, LSB first
// UART_STOP  | stop bit, line high; a new byte may be accepted on its last cycle
module uart_tx_core
  import dmem_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       busy,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_TC = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          frame_done;
  logic          accept;

  // Accepting on the final stop cycle gives back-to-back frames with no idle gap.
  assign frame_done = (state == UART_STOP) && (baud_cnt == '0);
  assign accept     = start && ((state == UART_IDLE) || frame_done);
  assign busy       = (state != UART_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= UART_IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'd0;
      tx       <= 1'b1;
    end else if (accept) begin
      state    <= UART_START;
      baud_cnt <= BAUD_TC;
      bit_idx  <= 3'd0;
      shreg    <= byte_in;
      tx       <= 1'b0;
    end else if (state != UART_IDLE) begin
      if (baud_cnt != '0) begin
        baud_cnt <= baud_cnt - 1'b1;
      end else begin
        baud_cnt <= BAUD_TC;
        case (state)
          UART_START: begin
            state <= UART_DATA;
            tx    <= shreg[0];
          end
          UART_DATA: begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= UART_STOP;
              tx    <= 1'b1;
            end else begin
              shreg <= {1'b0, shreg[7:1]};
              tx    <= shreg[1];
            end
          end
          UART_STOP: begin
            state    <= UART_IDLE;
            baud_cnt <= '0;
          end
          default: state <= UART_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data-bus responder: byte-writable RAM plus MMIO window (LED, CYCLE counter, UART TX).
// Read data is registered; a read during a write to the same location returns the old value.
module dmem_mmio
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 1024,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr,
  input  logic [3:0]  data_wr_en,
  output logic [31:0] data_rd,
  output logic [7:0]  led,
  output logic        uart_tx
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   ram [DEPTH_WORDS];
  logic [31:0]   cycle;
  logic          uart_busy;
  logic          is_mmio;
  logic [1:0]    mmio_off;
  logic [AW-1:0] word_idx;
  logic          mmio_wr;
  logic          uart_start;
  logic [31:0]   mmio_rd;
  logic          unused_addr;

  assign is_mmio    = data_addr[MMIO_BASE_BIT];
  assign mmio_off   = data_addr[3:2];
  assign word_idx   = data_addr[AW+1:2];
  assign mmio_wr    = is_mmio && data_wr_en[0];
  assign uart_start = mmio_wr && (mmio_off == MMIO_UART_DATA);
  // Upper RAM address bits alias; MMIO ignores everything but [31] and [3:2].
  assign unused_addr = ^{data_addr[30:AW+2], data_addr[1:0]};

  // RAM has no reset and still takes a store issued alongside rst.
  always_ff @(posedge clk) begin
    if (!is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (data_wr_en[i]) ram[word_idx][8*i +: 8] <= data_wr[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led <= 8'd0;
    end else if (mmio_wr && (mmio_off == MMIO_LED)) begin
      led <= data_wr[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cycle <= 32'd0;
    else     cycle <= cycle + 32'd1;
  end

  always_comb begin
    mmio_rd = 32'd0;
    case (mmio_off)
      MMIO_LED:       mmio_rd = {24'd0, led};
      MMIO_CYCLE:     mmio_rd = cycle;
      MMIO_UART_STAT: mmio_rd = {31'd0, uart_busy};
      default:        mmio_rd = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)          data_rd <= 32'd0;
    else if (is_mmio) data_rd <= mmio_rd;
    else              data_rd <= ram[word_idx];
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk    (clk),
    .rst    (rst),
    .start  (uart_start),
    .byte_in(data_wr[7:0]),
    .busy   (uart_busy),
    .tx     (uart_tx)
  );

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed cases plus random traffic against a frame-timing model.
module tb_dmem_mmio;

  localparam int DEPTH = 1024;
  localparam int C     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_addr;
  logic [31:0] data_wr;
  logic [3:0]  data_wr_en;
  logic [31:0] data_rd;
  logic [7:0]  led;
  logic        uart_tx;

  dmem_mmio #(.DEPTH_WORDS(DEPTH), .CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_addr (data_addr),
    .data_wr   (data_wr),
    .data_wr_en(data_wr_en),
    .data_rd   (data_rd),
    .led       (led),
    .uart_tx   (uart_tx)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [31:0] mref [DEPTH];
  logic [7:0]  led_m  = 8'd0;
  logic [31:0] cyc_m  = 32'd0;
  int          edge_n = 0;
  int          fs     = 0;
  bit          act    = 1'b0;
  logic [7:0]  ub     = 8'd0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // One bus cycle: drive, model the edge, compare all outputs just after it.
  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] w, input logic [3:0] e);
    logic [31:0] exp_rd;
    logic        busy_pre;
    logic        exp_tx;
    int          idx, k;
    rst = r; data_addr = a; data_wr = w; data_wr_en = e;
    edge_n++;
    busy_pre = act && ((edge_n - fs) <= 10 * C);
    idx = int'((a >> 2) % DEPTH);
    if (r) exp_rd = 32'd0;
    else if (a[31]) begin
      case (a[3:2])
        2'd0:    exp_rd = {24'd0, led_m};
        2'd1:    exp_rd = cyc_m;
        2'd3:    exp_rd = {31'd0, busy_pre};
        default: exp_rd = 32'd0;
      endcase
    end else exp_rd = mref[idx];

    @(posedge clk);
    if (!a[31]) begin
      for (int i = 0; i < 4; i++) if (e[i]) mref[idx][8*i +: 8] = w[8*i +: 8];
    end
    if (r) begin
      led_m = 8'd0;
      cyc_m = 32'd0;
      act   = 1'b0;
    end else begin
      if (a[31] && a[3:2] == 2'd0 && e[0]) led_m = w[7:0];
      cyc_m = cyc_m + 32'd1;
      if (a[31] && a[3:2] == 2'd2 && e[0] && (!act || (edge_n - fs) >= 10 * C)) begin
        act = 1'b1;
        fs  = edge_n;
        ub  = w[7:0];
      end
    end
    if (!act || (edge_n - fs) >= 10 * C) exp_tx = 1'b1;
    else begin
      k = (edge_n - fs) / C;
      if (k == 0)      exp_tx = 1'b0;
      else if (k == 9) exp_tx = 1'b1;
      else             exp_tx = ub[k-1];
    end
    #1;
    check("rd", data_rd, exp_rd);
    check("led", {24'd0, led}, {24'd0, led_m});
    check("tx", {31'd0, uart_tx}, {31'd0, exp_tx});
    @(negedge clk);
  endtask

  logic [31:0] cap [9];
  logic [9:0]  pat;
  logic [31:0] a;
  int          op;

  initial begin
    rst = 1'b1; data_addr = 32'd0; data_wr = 32'd0; data_wr_en = 4'd0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_rd", data_rd, 32'd0);
    check("rst_led", {24'd0, led}, 32'd0);
    check("rst_tx", {31'd0, uart_tx}, 32'd1);
    step(0, 32'h8000_000C, 0, 0);
    check("rst_stat", data_rd, 32'd0);

    for (int i = 0; i < 16; i++) step(0, 32'(4 * i), $urandom, 4'hF);

    // byte lanes
    step(0, 32'h10, 32'hDDCC_BBAA, 4'hF);
    step(0, 32'h10, 32'h0000_EE00, 4'h2);
    step(0, 32'h10, 0, 0);
    check("lanes", data_rd, 32'hDDCC_EEAA);

    // read during write
    step(0, 32'h20, 32'h1, 4'hF);
    step(0, 32'h20, 32'h2, 4'hF);
    check("rdw_old", data_rd, 32'h1);
    step(0, 32'h20, 0, 0);
    check("rdw_new", data_rd, 32'h2);

    // cycle counter
    step(1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      step(0, 32'h8000_0004, 0, 0);
      cap[i] = data_rd;
    end
    check("cyc_e5", cap[5], 32'd4);
    check("cyc_diff", cap[8] - cap[5], 32'd3);

    // UART frame 0x55
    pat = {1'b1, 8'h55, 1'b0};
    step(0, 32'h8000_0008, 32'h55, 4'h1);
    check("u55_start", {31'd0, uart_tx}, 32'd0);
    for (int off = 1; off < 40; off++) begin
      step(0, 32'h8000_000C, 0, 0);
      check("u55_bit", {31'd0, uart_tx}, {31'd0, pat[off / C]});
      check("u55_stat", data_rd, 32'd1);
    end
    step(0, 32'h8000_000C, 0, 0);
    check("u55_end_tx", {31'd0, uart_tx}, 32'd1);
    check("u55_end_stat", data_rd, 32'd1);
    step(0, 32'h8000_000C, 0, 0);
    check("u55_idle_stat", data_rd, 32'd0);

    // busy drop, then back-to-back restart
    step(0, 32'h8000_0008, 32'hA5, 4'h1);
    for (int off = 1; off < 40; off++) begin
      if (off == 12) step(0, 32'h8000_0008, 32'h3C, 4'h1);
      else           step(0, 32'h8000_000C, 0, 0);
      if (off == 20) check("drop_b4", {31'd0, uart_tx}, 32'd0);
    end
    step(0, 32'h8000_0008, 32'h3C, 4'h1);
    check("restart_tx", {31'd0, uart_tx}, 32'd0);
    step(0, 32'h8000_000C, 0, 0);
    check("restart_busy", data_rd, 32'd1);
    for (int off = 2; off < 42; off++) step(0, 32'h8000_000C, 0, 0);

    // reset mid-frame
    step(0, 32'h8000_0000, 32'h5A, 4'h1);
    step(0, 32'h30, 32'hCAFE_F00D, 4'hF);
    step(0, 32'h8000_0008, 32'hC3, 4'h1);
    for (int i = 0; i < 12; i++) step(0, 32'h8000_0000, 0, 0);
    step(1, 32'h34, 32'h1234_5678, 4'hF);
    check("mrst_tx", {31'd0, uart_tx}, 32'd1);
    check("mrst_led", {24'd0, led}, 32'd0);
    check("mrst_rd", data_rd, 32'd0);
    step(0, 32'h30, 0, 0);
    check("mrst_ram0", data_rd, 32'hCAFE_F00D);
    step(0, 32'h34, 0, 0);
    check("mrst_ram1", data_rd, 32'h1234_5678);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      op = int'($urandom_range(0, 9));
      a  = $urandom;
      case (op)
        0, 1, 2, 3:
          step(0, {1'b0, a[30:12], 6'd0, a[5:2], 2'b00}, $urandom, 4'($urandom_range(0, 15)));
        4: step(0, {1'b1, a[30:4], 2'd0, 2'b00}, $urandom, 4'($urandom_range(0, 15)));
        5: step(0, {1'b1, a[30:4], 2'd1, 2'b00}, $urandom, 4'($urandom_range(0, 15)));
        6: step(0, {1'b1, a[30:4], 2'd2, 2'b00}, $urandom, 4'($urandom_range(0, 3)));
        7: step(0, {1'b1, a[30:4], 2'd3, 2'b00}, $urandom, 4'($urandom_range(0, 15)));
        8: step(0, 32'd0, 0, 0);
        default: begin
          if ($urandom_range(0, 19) == 0)
            step(1, {1'b0, a[30:12], 6'd0, a[5:2], 2'b00}, $urandom, 4'($urandom_range(0, 15)));
          else
            step(0, {1'b0, a[30:12], 6'd0, a[5:2], 2'b00}, 0, 0);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
